// File: rtl/gemm_pkg.sv
// Shared state type, address type and counter sizing for the GEMM loop sequencer.
package gemm_pkg;

  localparam int GEMM_ADDR_WIDTH  = 16;
  localparam int GEMM_MATRIX_SIZE = 32;
  localparam int CNT_W            = $clog2(GEMM_MATRIX_SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } gemm_seq_state_t;

  typedef logic [GEMM_ADDR_WIDTH-1:0] gemm_addr_t;

  // Loop-counter width for an arbitrary matrix size; never narrower than one bit.
  function automatic int gemm_cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gemm_seq_delay.sv
// Valid + payload shift register of DEPTH stages; shifts every cycle, flush clears all stages.
module gemm_seq_delay #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             pending_o
);

  // occ_d[0] is the incoming slot, occ_d[s+1] is stage s.
  logic [DEPTH:0] occ_d;

  assign occ_d[0] = valid_i;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             valid_q;
      logic [WIDTH-1:0] data_q;
      logic             valid_in_d;
      logic [WIDTH-1:0] data_in_d;

      if (gi == 0) begin : g_head
        assign valid_in_d = valid_i;
        assign data_in_d  = data_i;
      end else begin : g_body
        assign valid_in_d = g_stage[gi-1].valid_q;
        assign data_in_d  = g_stage[gi-1].data_q;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else if (flush_i) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else begin
          valid_q <= valid_in_d;
          data_q  <= data_in_d;
        end
      end

      assign occ_d[gi+1] = valid_q;
    end
  endgenerate

  assign valid_o = g_stage[DEPTH-1].valid_q;
  assign data_o  = g_stage[DEPTH-1].data_q;

  // True while something other than the output stage will still be in flight after the next shift.
  assign pending_o = |occ_d[DEPTH-1:0];

endmodule

// File: rtl/gemm_loop_sequencer.sv
// i/j/k loop-nest sequencer for C = A*B over row-major memories, with a C write-back delay line.
// Optional GEMM_SEQ_PERF_EN adds perf_stall_cycles (RUN cycles with rd_ready low).
module gemm_loop_sequencer
  import gemm_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int MATRIX_SIZE = 32,
  parameter int MAC_LAT     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] a_addr,
  output logic [ADDR_WIDTH-1:0] b_addr,
  output logic                  mac_first,
  output logic                  c_wr_en,
  output logic [ADDR_WIDTH-1:0] c_addr
`ifdef GEMM_SEQ_PERF_EN
  ,
  output logic [31:0]           perf_stall_cycles
`endif
);

  localparam int CW = gemm_cnt_width(MATRIX_SIZE);
  localparam logic [CW-1:0]         LAST_IDX = CW'(MATRIX_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] N_ADDR   = ADDR_WIDTH'(MATRIX_SIZE);
  localparam bit PARAMS_OK = (DATA_WIDTH > 0) && (MATRIX_SIZE >= 2) && (MAC_LAT >= 1) &&
                             ((longint'(MATRIX_SIZE) * MATRIX_SIZE) <= (longint'(1) << ADDR_WIDTH));

  generate
    if (!PARAMS_OK) begin : g_param_check
      $error("gemm_loop_sequencer: illegal DATA_WIDTH/MATRIX_SIZE/MAC_LAT/ADDR_WIDTH combination");
    end
  endgenerate

  gemm_seq_state_t state_q;
  logic [CW-1:0]         i_q, j_q, k_q;
  logic [ADDR_WIDTH-1:0] a_base_q;   // i*N
  logic [ADDR_WIDTH-1:0] b_base_q;   // k*N
  logic                  busy_q, done_q, rd_en_q, mac_first_q, last_k_q;
  logic [ADDR_WIDTH-1:0] a_addr_q, b_addr_q, c_pend_q;

  logic issue_d, k_last_d, j_last_d, i_last_d;
  logic dly_valid_d, dly_pending_d;
  logic [ADDR_WIDTH-1:0] dly_addr_d;

  assign issue_d  = (state_q == RUN) && rd_ready && !abort;
  assign k_last_d = (k_q == LAST_IDX);
  assign j_last_d = (j_q == LAST_IDX);
  assign i_last_d = (i_q == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      a_base_q    <= '0;
      b_base_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      mac_first_q <= 1'b0;
      last_k_q    <= 1'b0;
      a_addr_q    <= '0;
      b_addr_q    <= '0;
      c_pend_q    <= '0;
    end else begin
      rd_en_q     <= issue_d;
      mac_first_q <= issue_d && (k_q == '0);
      last_k_q    <= issue_d && k_last_d;
      done_q      <= 1'b0;
      if (issue_d) begin
        a_addr_q <= a_base_q + ADDR_WIDTH'(k_q);
        b_addr_q <= b_base_q + ADDR_WIDTH'(j_q);
        c_pend_q <= a_base_q + ADDR_WIDTH'(j_q);
      end

      // abort wins over start and over every in-flight state.
      if (abort) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q  <= RUN;
              busy_q   <= 1'b1;
              i_q      <= '0;
              j_q      <= '0;
              k_q      <= '0;
              a_base_q <= '0;
              b_base_q <= '0;
            end
          end
          RUN: begin
            if (rd_ready) begin
              if (!k_last_d) begin
                k_q      <= k_q + CW'(1);
                b_base_q <= b_base_q + N_ADDR;
              end else begin
                k_q      <= '0;
                b_base_q <= '0;
                if (!j_last_d) begin
                  j_q <= j_q + CW'(1);
                end else begin
                  j_q <= '0;
                  if (!i_last_d) begin
                    i_q      <= i_q + CW'(1);
                    a_base_q <= a_base_q + N_ADDR;
                  end else begin
                    i_q      <= '0;
                    a_base_q <= '0;
                    state_q  <= DRAIN;
                  end
                end
              end
            end
          end
          DRAIN: begin
            if (!dly_pending_d) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Retire path: an element completes MAC_LAT cycles after its k == N-1 read is presented.
  gemm_seq_delay #(
    .DEPTH (MAC_LAT),
    .WIDTH (ADDR_WIDTH)
  ) u_c_delay (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (abort),
    .valid_i   (last_k_q),
    .data_i    (c_pend_q),
    .valid_o   (dly_valid_d),
    .data_o    (dly_addr_d),
    .pending_o (dly_pending_d)
  );

`ifdef GEMM_SEQ_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if ((state_q == IDLE) && start && !abort) begin
      stall_cnt_q <= '0;
    end else if ((state_q == RUN) && !rd_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign a_addr    = a_addr_q;
  assign b_addr    = b_addr_q;
  assign mac_first = mac_first_q;
  assign c_wr_en   = dly_valid_d;
  assign c_addr    = dly_addr_d;

endmodule

// File: tb/tb_gemm_loop_sequencer.sv
// Randomised bench for gemm_loop_sequencer (N=4, MAC_LAT=3) against a loop-nest reference model.
module tb_gemm_loop_sequencer;

  localparam int N          = 4;
  localparam int LAT        = 3;
  localparam int AW         = 16;
  localparam int RUN_BUDGET = 3000;

  logic          clk, reset, start, abort, rd_ready;
  logic          busy, done, rd_en, mac_first, c_wr_en;
  logic [AW-1:0] a_addr, b_addr, c_addr;
`ifdef GEMM_SEQ_PERF_EN
  logic [31:0]   perf_stall_cycles;
`endif

  gemm_loop_sequencer #(
    .DATA_WIDTH  (16),
    .ADDR_WIDTH  (AW),
    .MATRIX_SIZE (N),
    .MAC_LAT     (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .rd_ready  (rd_ready),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .a_addr    (a_addr),
    .b_addr    (b_addr),
    .mac_first (mac_first),
    .c_wr_en   (c_wr_en),
    .c_addr    (c_addr)
`ifdef GEMM_SEQ_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [AW-1:0] c;
    logic          first;
    logic          lastk;
  } rd_t;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    bit            fin;
  } cw_t;

  rd_t rdq[$];
  cw_t cwq[$];
  int  cyc, done_due, n_checks, n_errors;
  int  rd_cnt, cw_cnt, done_cnt, first_rd_cyc, last_rd_cyc, start_cyc;
  bit  m_busy, idle_now;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: the full read schedule of one multiply, in issue order.
  task automatic load_model();
    rd_t e;
    rdq.delete();
    cwq.delete();
    done_due = -1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        for (int k = 0; k < N; k++) begin
          e.a     = AW'(i * N + k);
          e.b     = AW'(k * N + j);
          e.c     = AW'(i * N + j);
          e.first = (k == 0);
          e.lastk = (k == N - 1);
          rdq.push_back(e);
        end
  endtask

  task automatic clear_model();
    rdq.delete();
    cwq.delete();
    done_due = -1;
    m_busy   = 1'b0;
  endtask

  task automatic monitor();
    rd_t e;
    cw_t w;
    bit  exp_cw;
    cyc++;
    check("busy", busy, m_busy);
    idle_now = !m_busy;
    while (cwq.size() > 0 && cwq[0].cyc < cyc) void'(cwq.pop_front());
    if (rd_en) begin
      rd_cnt++;
      if (rd_cnt == 1) first_rd_cyc = cyc;
      last_rd_cyc = cyc;
      check("rd_gate", rd_ready, 1'b1);
      if (rdq.size() == 0) begin
        check("rd_extra", rd_en, 1'b0);
      end else begin
        e = rdq.pop_front();
        check("a_addr", a_addr, e.a);
        check("b_addr", b_addr, e.b);
        check("mac_first", mac_first, e.first);
        if (e.lastk) begin
          w.cyc  = cyc + LAT;
          w.addr = e.c;
          w.fin  = (rdq.size() == 0);
          cwq.push_back(w);
        end
      end
    end
    exp_cw = (cwq.size() > 0) && (cwq[0].cyc == cyc);
    check("c_wr_en", c_wr_en, exp_cw);
    if (exp_cw) begin
      w = cwq.pop_front();
      check("c_addr", c_addr, w.addr);
      cw_cnt++;
      if (w.fin) done_due = cyc + 1;
    end
    check("done", done, cyc == done_due);
    if (done) done_cnt++;
    if (cyc == done_due) m_busy = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
  endtask

  task automatic drive(input logic st, input logic ab, input logic rdy);
    start    = st;
    abort    = ab;
    rd_ready = rdy;
    if (ab) begin
      if (!idle_now) clear_model();
    end else if (st && idle_now) begin
      load_model();
      m_busy    = 1'b1;
      start_cyc = cyc;
    end
  endtask

  function automatic logic rdy_pat(input int mode, input int t);
    case (mode)
      1:       return logic'(t % 2);
      2:       return (t > 10);
      3:       return ($urandom_range(0, 3) != 0);
      default: return 1'b1;
    endcase
  endfunction

  task automatic do_run(input string tag, input int mode, input int abort_at);
    int t, since_abort;
    bit aborted, got_done, st, ab;
    rd_cnt = 0; cw_cnt = 0; done_cnt = 0; first_rd_cyc = -1; last_rd_cyc = -1;
    aborted = 0; since_abort = 0; got_done = 0;
    check("idle_before_start", busy, 1'b0);
    drive(1'b1, 1'b0, rdy_pat(mode, 0));
    t = 1;
    for (int n = 0; n < RUN_BUDGET; n++) begin
      step();
      if (done) begin
        got_done = 1;
        break;
      end
      if (aborted) begin
        since_abort++;
        if (since_abort >= 20) break;
      end
      ab = (abort_at > 0) && !aborted && rd_en && (rd_cnt == abort_at);
      if (ab) aborted = 1;
      st = (mode == 3) && !idle_now && ($urandom_range(0, 2) == 0);
      drive(st, ab, rdy_pat(mode, t));
      t++;
    end
    if (abort_at == 0) begin
      check("done_seen", got_done, 1'b1);
`ifdef GEMM_SEQ_PERF_EN
      if (mode == 2) check("perf_stall", perf_stall_cycles, 10);
`endif
      drive(1'b0, 1'b0, 1'b1);
      step();
      check("rd_total", rd_cnt, N * N * N);
      check("cw_total", cw_cnt, N * N);
      check("done_total", done_cnt, 1);
      if (mode == 0) begin
        check("rd_contiguous", last_rd_cyc - first_rd_cyc, N * N * N - 1);
        check("rd_latency", first_rd_cyc - start_cyc, 2);
      end
    end else begin
      check("abort_rd_total", rd_cnt, abort_at);
      check("abort_done_total", done_cnt, 0);
      check("abort_busy", busy, 1'b0);
    end
    $display("run %s: rd_en=%0d c_wr_en=%0d done=%0d end_cycle=%0d", tag, rd_cnt, cw_cnt, done_cnt, cyc);
  endtask

  task automatic reset_in_drain();
    rd_cnt = 0; cw_cnt = 0; done_cnt = 0;
    drive(1'b1, 1'b0, 1'b1);
    for (int n = 0; n < RUN_BUDGET; n++) begin
      step();
      if (rd_cnt == N * N * N) break;
      drive(1'b0, 1'b0, 1'b1);
    end
    check("drain_reached", rd_cnt, N * N * N);
    #2 reset = 1'b1;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_c_wr_en", c_wr_en, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_a_addr", a_addr, '0);
    check("rst_c_addr", c_addr, '0);
    clear_model();
    drive(1'b0, 1'b0, 1'b1);
    step();
    step();
    reset = 1'b0;
    repeat (10) step();
    check("rst_no_done", done_cnt, 0);
    $display("run reset_in_drain: rd_en=%0d c_wr_en=%0d done=%0d end_cycle=%0d", rd_cnt, cw_cnt, done_cnt, cyc);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; rd_ready = 1'b0;
    cyc = 0; done_due = -1; n_checks = 0; n_errors = 0;
    m_busy = 1'b0; idle_now = 1'b1;
    repeat (2) step();
    check("reset_rd_en", rd_en, 1'b0);
    check("reset_mac_first", mac_first, 1'b0);
    check("reset_a_addr", a_addr, '0);
    check("reset_b_addr", b_addr, '0);
    check("reset_c_addr", c_addr, '0);
`ifdef GEMM_SEQ_PERF_EN
    check("reset_perf", perf_stall_cycles, 0);
`endif
    reset = 1'b0;
    step();

    do_run("sequential", 0, 0);
    do_run("toggle_ready", 1, 0);
    do_run("abort_at_20", 0, 20);
    do_run("after_abort", 0, 0);
    do_run("random_start_a", 3, 0);
    do_run("random_start_b", 3, 0);
    do_run("stall_10", 2, 0);
    reset_in_drain();
    do_run("after_reset", 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
